// File: rtl/vga_pattern_sequencer.sv
// VGA timing counters and frame-synchronous test-pattern scheduler.
// rst_ni is asserted asynchronously and is expected to be released synchronously to clk_i.
module vga_pattern_sequencer #(
  parameter int unsigned TOTAL_COLS   = 800,
  parameter int unsigned TOTAL_ROWS   = 525,
  parameter int unsigned ACTIVE_COLS  = 640,
  parameter int unsigned ACTIVE_ROWS  = 480,
  parameter int unsigned SEL_WIDTH    = 3,
  parameter int unsigned NUM_PATTERNS = 8,
  parameter int unsigned AUTO_FRAMES  = 60
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 next_req_i,
  input  logic                 auto_en_i,
  output logic [9:0]           col_o,
  output logic [9:0]           row_o,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 frame_start_o,
  output logic [SEL_WIDTH-1:0] pattern_sel_o,
  output logic                 pending_o,
  output logic                 req_ack_o
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned FCNT_W = 8;

  localparam logic [CNT_W-1:0]     COL_LAST = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0]     ROW_LAST = CNT_W'(TOTAL_ROWS - 1);
  localparam logic [CNT_W-1:0]     COL_ACT  = CNT_W'(ACTIVE_COLS);
  localparam logic [CNT_W-1:0]     ROW_ACT  = CNT_W'(ACTIVE_ROWS);
  localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(NUM_PATTERNS - 1);
  localparam logic [FCNT_W-1:0]    FRM_LAST = FCNT_W'(AUTO_FRAMES - 1);

  typedef enum logic {
    HOLD    = 1'b0,
    PENDING = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     col_q, col_d;
  logic [CNT_W-1:0]     row_q, row_d;
  logic                 hsync_q;
  logic                 vsync_q;
  logic                 frame_start_q;
  logic [SEL_WIDTH-1:0] pattern_sel_q, pattern_sel_d;
  logic                 req_ack_q;
  logic [FCNT_W-1:0]    frame_cnt_q, frame_cnt_d;

  logic col_wrap;
  logic boundary;
  logic manual_adv;
  logic auto_adv;
  logic advance;

  // Raster counters; boundary marks the last pixel of the frame.
  always_comb begin
    col_wrap = (col_q == COL_LAST);
    boundary = col_wrap && (row_q == ROW_LAST);
    col_d    = col_wrap ? '0 : col_q + CNT_W'(1);
    row_d    = row_q;
    if (col_wrap) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + CNT_W'(1);
    end
  end

  // Request FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // A request in the boundary cycle itself is served at that boundary without parking in PENDING.
  always_comb begin
    state_d    = state_q;
    manual_adv = 1'b0;
    case (state_q)
      HOLD: begin
        if (next_req_i) begin
          if (boundary) begin
            manual_adv = 1'b1;
          end else begin
            state_d = PENDING;
          end
        end
      end
      PENDING: begin
        if (boundary) begin
          manual_adv = 1'b1;
          state_d    = HOLD;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  // Advance arbitration: manual and auto expiry merge into a single step.
  always_comb begin
    auto_adv      = boundary && auto_en_i && (frame_cnt_q == FRM_LAST);
    advance       = manual_adv || auto_adv;
    pattern_sel_d = pattern_sel_q;
    if (advance) begin
      pattern_sel_d = (pattern_sel_q == SEL_LAST) ? '0 : pattern_sel_q + SEL_WIDTH'(1);
    end
    frame_cnt_d = frame_cnt_q;
    if (!auto_en_i) begin
      frame_cnt_d = '0;
    end else if (boundary) begin
      frame_cnt_d = advance ? '0 : frame_cnt_q + FCNT_W'(1);
    end
  end

  // Outputs are computed from next-count values so they line up with col/row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q         <= '0;
      row_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
      pattern_sel_q <= '0;
      req_ack_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      hsync_q       <= (col_d < COL_ACT);
      vsync_q       <= (row_d < ROW_ACT);
      frame_start_q <= boundary;
      pattern_sel_q <= pattern_sel_d;
      req_ack_q     <= manual_adv;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign col_o         = col_q;
  assign row_o         = row_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign frame_start_o = frame_start_q;
  assign pattern_sel_o = pattern_sel_q;
  assign pending_o     = (state_q == PENDING);
  assign req_ack_o     = req_ack_q;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Scoreboard bench for vga_pattern_sequencer on a shrunken 10x6 raster (60-cycle frames).
module tb_vga_pattern_sequencer;

  localparam int unsigned TC = 10;
  localparam int unsigned TR = 6;
  localparam int unsigned AC = 8;
  localparam int unsigned AR = 4;
  localparam int unsigned SW = 3;
  localparam int unsigned NP = 8;
  localparam int unsigned AF = 2;

  logic          clk;
  logic          rst_n;
  logic          next_req;
  logic          auto_en;
  logic [9:0]    col_o;
  logic [9:0]    row_o;
  logic          hsync_o;
  logic          vsync_o;
  logic          frame_start_o;
  logic [SW-1:0] pattern_sel_o;
  logic          pending_o;
  logic          req_ack_o;

  vga_pattern_sequencer #(
    .TOTAL_COLS  (TC),
    .TOTAL_ROWS  (TR),
    .ACTIVE_COLS (AC),
    .ACTIVE_ROWS (AR),
    .SEL_WIDTH   (SW),
    .NUM_PATTERNS(NP),
    .AUTO_FRAMES (AF)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .next_req_i   (next_req),
    .auto_en_i    (auto_en),
    .col_o        (col_o),
    .row_o        (row_o),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .frame_start_o(frame_start_o),
    .pattern_sel_o(pattern_sel_o),
    .pending_o    (pending_o),
    .req_ack_o    (req_ack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_rst;
    int unsigned cyc;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [SW-1:0] sel;
    logic        pend;
    logic        ack;
  } snap_t;

  typedef struct {
    string         name;
    logic [SW-1:0] sel;
    logic          ack;
  } fs_t;

  snap_t       snap_q[$];
  fs_t         fs_q[$];
  int unsigned cyc;
  int          checks = 0;
  int          failures = 0;

  // Cycle index since the latest reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic exp_at(string n, int unsigned c, int unsigned col, int unsigned row,
                        bit hs, bit vs, bit fs, int unsigned sel, bit pend, bit ack);
    snap_t s;
    s.name = n; s.is_rst = 1'b0; s.cyc = c;
    s.col = 10'(col); s.row = 10'(row);
    s.hs = hs; s.vs = vs; s.fs = fs;
    s.sel = SW'(sel); s.pend = pend; s.ack = ack;
    snap_q.push_back(s);
  endtask

  task automatic exp_rst(string n);
    snap_t s;
    s.name = n; s.is_rst = 1'b1; s.cyc = 0;
    s.col = 10'd0; s.row = 10'd0;
    s.hs = 1'b1; s.vs = 1'b1; s.fs = 1'b0;
    s.sel = '0; s.pend = 1'b0; s.ack = 1'b0;
    snap_q.push_back(s);
  endtask

  task automatic exp_fs(string n, int unsigned sel, bit ack);
    fs_t f;
    f.name = n; f.sel = SW'(sel); f.ack = ack;
    fs_q.push_back(f);
  endtask

  function automatic void cmp_snap(snap_t e);
    checks++;
    if (col_o !== e.col || row_o !== e.row || hsync_o !== e.hs || vsync_o !== e.vs ||
        frame_start_o !== e.fs || pattern_sel_o !== e.sel || pending_o !== e.pend ||
        req_ack_o !== e.ack) begin
      failures++;
      $display("FAIL %s: got col=%0d row=%0d hs=%0b vs=%0b fs=%0b sel=%0d pend=%0b ack=%0b, want col=%0d row=%0d hs=%0b vs=%0b fs=%0b sel=%0d pend=%0b ack=%0b",
               e.name, col_o, row_o, hsync_o, vsync_o, frame_start_o, pattern_sel_o, pending_o, req_ack_o,
               e.col, e.row, e.hs, e.vs, e.fs, e.sel, e.pend, e.ack);
    end
  endfunction

  // Monitor: snapshot entries at their cycle, frame-start entries on every frame_start pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (snap_q.size() > 0 && snap_q[0].is_rst) cmp_snap(snap_q.pop_front());
    end else begin
      while (snap_q.size() > 0 && !snap_q[0].is_rst && snap_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s: cycle %0d never sampled (now %0d)", snap_q[0].name, snap_q[0].cyc, cyc);
        void'(snap_q.pop_front());
      end
      if (snap_q.size() > 0 && !snap_q[0].is_rst && snap_q[0].cyc == cyc) cmp_snap(snap_q.pop_front());
      if (frame_start_o) begin
        checks++;
        if (fs_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_frame_start: at cycle %0d sel=%0d ack=%0b, want no pulse",
                   cyc, pattern_sel_o, req_ack_o);
        end else begin
          fs_t f;
          f = fs_q.pop_front();
          if (pattern_sel_o !== f.sel || req_ack_o !== f.ack) begin
            failures++;
            $display("FAIL %s: at cycle %0d got sel=%0d ack=%0b, want sel=%0d ack=%0b",
                     f.name, cyc, pattern_sel_o, req_ack_o, f.sel, f.ack);
          end
        end
      end
    end
  end

  task automatic goto(int unsigned n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req(int unsigned n);
    goto(n);
    next_req = 1'b1;
    goto(n + 1);
    next_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Expected pattern at successive frame starts once auto mode is on (from cycle 300).
  logic [SW-1:0] auto_sel [14];

  initial begin
    auto_sel = '{3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
    rst_n    = 1'b0;
    next_req = 1'b0;
    auto_en  = 1'b0;

    exp_rst("reset_init");
    exp_at("c0_start",      0, 0, 0, 1, 1, 0, 0, 0, 0);
    exp_at("c7_last_act",   7, 7, 0, 1, 1, 0, 0, 0, 0);
    exp_at("c8_hblank",     8, 8, 0, 0, 1, 0, 0, 0, 0);
    exp_at("c10_row1",     10, 0, 1, 1, 1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single manual request mid-frame.
    exp_at("c16_pending",  16, 6, 1, 1, 1, 0, 0, 1, 0);
    exp_at("c39_last_vis", 39, 9, 3, 0, 1, 0, 0, 1, 0);
    exp_at("c40_vblank",   40, 0, 4, 1, 0, 0, 0, 1, 0);
    exp_at("c59_boundary", 59, 9, 5, 0, 0, 0, 0, 1, 0);
    exp_at("c60_advance",  60, 0, 0, 1, 1, 1, 1, 0, 1);
    exp_at("c61_ack_drop", 61, 1, 0, 1, 1, 0, 1, 0, 0);
    exp_fs("fs60_manual", 1, 1'b1);
    pulse_req(15);

    // Three requests in one frame give one step.
    exp_at("c71_pending",  71, 1, 1, 1, 1, 0, 1, 1, 0);
    exp_at("c120_single", 120, 0, 0, 1, 1, 1, 2, 0, 1);
    exp_at("c180_no_req", 180, 0, 0, 1, 1, 1, 2, 0, 0);
    exp_fs("fs120_triple", 2, 1'b1);
    exp_fs("fs180_idle", 2, 1'b0);
    pulse_req(70);
    pulse_req(80);
    pulse_req(90);

    // Request landing exactly in the boundary cycle while in HOLD.
    exp_at("c239_b_req",  239, 9, 5, 0, 0, 0, 2, 0, 0);
    exp_at("c240_b_adv",  240, 0, 0, 1, 1, 1, 3, 0, 1);
    exp_at("c241_hold",   241, 1, 0, 1, 1, 0, 3, 0, 0);
    exp_fs("fs240_b_req", 3, 1'b1);
    pulse_req(239);

    // Auto cycling every 2 frames, wrap 7->0, then manual request coinciding with expiry.
    auto_en = 1'b1;
    for (int i = 0; i < 14; i++) exp_fs($sformatf("fs_auto_%0d", 300 + 60 * i), auto_sel[i], i == 11);
    exp_at("c360_auto",   360, 0, 0, 1, 1, 1, 4, 0, 0);
    exp_at("c840_wrap",   840, 0, 0, 1, 1, 1, 0, 0, 0);
    exp_at("c959_coinc",  959, 9, 5, 0, 0, 0, 0, 0, 0);
    exp_at("c960_coinc",  960, 0, 0, 1, 1, 1, 1, 0, 1);
    exp_at("c961_coinc",  961, 1, 0, 1, 1, 0, 1, 0, 0);
    exp_at("c1080_auto", 1080, 0, 0, 1, 1, 1, 2, 0, 0);
    pulse_req(959);
    goto(1080);
    auto_en = 1'b0;

    // Reset mid-frame with a request parked.
    exp_at("c1101_pending", 1101, 1, 2, 1, 1, 0, 2, 1, 0);
    pulse_req(1100);
    goto(1110);
    #2;
    exp_rst("reset_midframe");
    exp_at("r0_restart",   0, 0, 0, 1, 1, 0, 0, 0, 0);
    exp_at("r1_discarded", 1, 1, 0, 1, 1, 0, 0, 0, 0);
    exp_at("r60_no_ack",  60, 0, 0, 1, 1, 1, 0, 0, 0);
    exp_at("r61_after",   61, 1, 0, 1, 1, 0, 0, 0, 0);
    exp_fs("fs_after_reset", 0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    goto(65);

    checks++;
    if (snap_q.size() != 0) begin
      failures++;
      $display("FAIL snap_drain: %0d entries left, want 0", snap_q.size());
    end
    checks++;
    if (fs_q.size() != 0) begin
      failures++;
      $display("FAIL frame_start_drain: %0d entries left, want 0", fs_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_pattern_sequencer.md
Name: vga_pattern_sequencer

Overview:
- Master VGA timing and pattern scheduler.
- Generates col/row counters and the raw active-region hsync/vsync consumed by the porch/sync-pulse stage.
- Selects which test-pattern source drives video. Pattern changes happen only at frame boundaries, on user request or by automatic cycling.
- Guarantees no mid-frame pattern tearing.

Parameters:
- TOTAL_COLS, 800, columns per line including blanking
- TOTAL_ROWS, 525, rows per frame including blanking
- ACTIVE_COLS, 640, visible columns
- ACTIVE_ROWS, 480, visible rows
- SEL_WIDTH, 3, width of pattern_sel
- NUM_PATTERNS, 8, number of patterns; 1 <= NUM_PATTERNS <= 2**SEL_WIDTH
- AUTO_FRAMES, 60, frames per pattern in auto mode; range 1..256

Ports:
- clock  in  1  system/pixel clock
- reset_n  in  1  asynchronous active-low reset
- next_req  in  1  request to advance pattern; level sampled every cycle, debounced upstream
- auto_en  in  1  enable automatic cycling
- col  out  10  current column counter
- row  out  10  current row counter
- hsync  out  1  high while col < ACTIVE_COLS
- vsync  out  1  high while row < ACTIVE_ROWS
- frame_start  out  1  one-cycle pulse at start of each frame
- pattern_sel  out  SEL_WIDTH  active pattern index
- pending  out  1  request latched, waiting for frame boundary
- req_ack  out  1  one-cycle pulse when a latched request is applied

Behaviour:
- Reset (async assert, sync release): col=0, row=0, hsync=1, vsync=1, frame_start=0, pattern_sel=0, pending=0, req_ack=0, frame_cnt=0, FSM=HOLD.
- Counters:
  - col increments each cycle and wraps TOTAL_COLS-1 -> 0.
  - row increments when col wraps, and wraps TOTAL_ROWS-1 -> 0.
- Boundary cycle B: the cycle in which col=TOTAL_COLS-1 and row=TOTAL_ROWS-1.
- All outputs are registered and aligned to col/row: hsync/vsync in a given cycle reflect that cycle's col/row (computed from next-count values).
- frame_start=1 exactly in cycles where col=0 and row=0 after a wrap. It is NOT asserted in the first cycle after reset release.
- FSM states:
  - HOLD: next_req=1 -> PENDING.
  - PENDING: on B -> HOLD, pattern advances.
  - next_req=1 in cycle B while in HOLD counts for that boundary: advance happens, FSM stays HOLD.
  - Repeated next_req while PENDING is absorbed; at most one advance per boundary.
  - pending output = (state == PENDING).
- Advance rule:
  - pattern_sel <= (pattern_sel == NUM_PATTERNS-1) ? 0 : pattern_sel+1.
  - The update appears in the same cycle as frame_start.
- Auto mode:
  - frame_cnt (8-bit) increments at each B while auto_en=1.
  - At B with auto_en=1 and frame_cnt == AUTO_FRAMES-1: advance, frame_cnt <= 0.
  - auto_en=0 holds frame_cnt at 0.
  - Any manual advance also clears frame_cnt.
- Simultaneous manual and auto expiry at the same B: single advance, req_ack=1, frame_cnt <= 0.
- req_ack=1 for one cycle, coincident with frame_start, only when a manual request caused or shared the advance. Auto-only advances give req_ack=0.
- NUM_PATTERNS=1: pattern_sel stays 0; requests still ack.
- Reset mid-frame: all state cleared immediately; pending request discarded; timing restarts at (0,0).
- Latency from next_req to new pattern: until next frame start, at most one frame + 1 cycle.

Test Plan:
- Release reset -> cycle 0: col=0, row=0, hsync=1, vsync=1, frame_start=0. At col=640: hsync=0. At cycle 800: col=0, row=1. At cycle 480*800: vsync=0. At cycle 420000: frame_start=1, col=0, row=0.
- next_req pulse at row=100 -> pending=1 next cycle, pattern_sel=0 through cycle 419999. At cycle 420000: pattern_sel=1, frame_start=1, req_ack=1, pending=0. req_ack=0 at cycle 420001.
- Three next_req pulses in one frame -> exactly one increment (0->1) at boundary. Next frame: pattern_sel unchanged, req_ack=0.
- AUTO_FRAMES=2, auto_en=1, no requests:
  - pattern_sel steps 0,0,1,1,2,... per frame.
  - After 8 increments it wraps 7 -> 0.
  - req_ack never asserts.
- AUTO_FRAMES=2, next_req asserted exactly in boundary cycle B coinciding with auto expiry -> single increment, req_ack=1. Next auto advance occurs 2 frames later.
- Assert reset_n=0 mid-frame (row=200, pending=1, pattern_sel=5) -> same cycle: col=0, row=0, pattern_sel=0, pending=0. No ack after release.
